bcd_seg_scanner: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 30 +++
 rtl/bcd_to_7seg.sv | 19 +
 rtl/bcd_seg_scanner.sv | 139 +++++++++++++
 tb/tb_bcd_seg_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared constants and width helpers for the BCD display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Active-high g..a patterns, entry 15 first; codes 10..15 render as a dash.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int cnt_width(input int refresh_div);
        return (refresh_div > 1) ? $clog2(refresh_div) : 1;
    endfunction

    function automatic int idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_7seg.sv
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD to active-high 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[bcd_i];

endmodule

`default_nettype wire

// File: rtl/bcd_seg_scanner.sv
// ============================================================================
// Module      : bcd_seg_scanner
// Description : Time-multiplexed 7-segment scanner with frame snapshot,
//               leading-zero blanking and anti-ghosting blank interval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seg_scanner
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_CYC   = 16,
    parameter bit ACTIVE_LOW  = 1'b1
)
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_lz_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int CW = cnt_width(REFRESH_DIV);
    localparam int IW = idx_width(NUM_DIGITS);

    localparam logic [CW-1:0]         c_CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         c_BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0]         c_IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_SEG_POL   = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] c_AN_POL    = {NUM_DIGITS{ACTIVE_LOW}};

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic                    r_blank_lz;
    logic [6:0]              r_seg;
    logic                    r_dp_out;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame;

    logic                    w_cnt_last;
    logic                    w_idx_last;
    logic                    w_frame_start;
    logic [3:0]              w_digit;
    logic                    w_digit_dp;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_zero_run;
    logic                    w_show;
    logic [6:0]              w_seg_dec;

    assign w_cnt_last    = (r_cnt == c_CNT_LAST);
    assign w_idx_last    = (r_idx == c_IDX_LAST);
    assign w_frame_start = (r_cnt == '0) && (r_idx == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The snapshot only changes while the whole display is in its blank interval.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_digits   <= '0;
            r_dp       <= '0;
            r_blank_lz <= 1'b0;
        end else if (w_frame_start) begin
            r_digits   <= digits_i;
            r_dp       <= dp_i;
            r_blank_lz <= blank_lz_i;
        end
    end

    always_comb begin
        w_digit    = 4'h0;
        w_digit_dp = 1'b0;
        w_an_sel   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_digit     = r_digits[4*k +: 4];
                w_digit_dp  = r_dp[k];
                w_an_sel[k] = 1'b1;
            end
        end
    end

    // Walk down from the most significant digit; a digit is blanked while the run of zeros holds.
    always_comb begin
        w_lz_mask  = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run   = w_zero_run & (r_digits[4*k +: 4] == 4'h0);
            w_lz_mask[k] = r_blank_lz & w_zero_run;
        end
    end

    bcd_to_7seg u_dec (
        .bcd_i (w_digit),
        .seg_o (w_seg_dec)
    );

    assign w_show = (r_cnt >= c_BLANK_END) && ((w_lz_mask & w_an_sel) == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_seg    <= SEG_OFF ^ c_SEG_POL;
            r_dp_out <= ACTIVE_LOW;
            r_an     <= c_AN_POL;
            r_frame  <= 1'b0;
        end else begin
            r_seg    <= (w_show ? w_seg_dec : SEG_OFF) ^ c_SEG_POL;
            r_dp_out <= (w_show & w_digit_dp) ^ ACTIVE_LOW;
            r_an     <= (w_show ? w_an_sel : '0) ^ c_AN_POL;
            r_frame  <= w_cnt_last & w_idx_last;
        end
    end

    assign seg_o   = r_seg;
    assign dp_o    = r_dp_out;
    assign an_o    = r_an;
    assign frame_o = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg_scanner.sv
// ============================================================================
// Module      : tb_bcd_seg_scanner
// Description : Self-checking bench for bcd_seg_scanner, active-high and
//               active-low instances driven from shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_seg_scanner;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic          clk;
    logic          rst_i;
    logic [15:0]   digits_i;
    logic [3:0]    dp_i;
    logic          blank_lz_i;

    logic [6:0]    seg0, seg1;
    logic          dp0, dp1;
    logic [3:0]    an0, an1;
    logic          fr0, fr1;
    logic [12:0]   o0, o1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    assign o0 = {fr0, dp0, an0, seg0};
    assign o1 = {fr1, dp1, an1, seg1};

    bcd_seg_scanner #(
        .NUM_DIGITS (ND), .REFRESH_DIV (RD), .BLANK_CYC (BC), .ACTIVE_LOW (1'b0)
    ) u_dut_hi (
        .clk_i (clk), .rst_i (rst_i), .digits_i (digits_i), .dp_i (dp_i),
        .blank_lz_i (blank_lz_i), .seg_o (seg0), .dp_o (dp0), .an_o (an0), .frame_o (fr0)
    );

    bcd_seg_scanner #(
        .NUM_DIGITS (ND), .REFRESH_DIV (RD), .BLANK_CYC (BC), .ACTIVE_LOW (1'b1)
    ) u_dut_lo (
        .clk_i (clk), .rst_i (rst_i), .digits_i (digits_i), .dp_i (dp_i),
        .blank_lz_i (blank_lz_i), .seg_o (seg1), .dp_o (dp1), .an_o (an1), .frame_o (fr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg_ref(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected {dp, an, seg} (active-high) for the display position p within a run.
    function automatic logic [11:0] model_out(input int p, input logic [15:0] sd,
                                              input logic [3:0] sdp, input logic sb);
        int cnt, idx, v;
        logic [15:0] upper;
        cnt = p % RD;
        idx = (p / RD) % ND;
        if (cnt < BC) return 12'h000;
        upper = sd >> (4 * idx);
        v = int'(upper & 16'h000F);
        if (sb && idx != 0 && upper == 16'h0000) return 12'h000;
        return {sdp[idx], 4'(1 << idx), seg_ref(v)};
    endfunction

    initial begin : compare
        int          p;
        bit          have;
        logic [15:0] sd;
        logic [3:0]  sdp;
        logic        sb;
        logic [11:0] e;
        logic        ef;
        have = 1'b0; p = 0; sd = '0; sdp = '0; sb = 1'b0; e = '0; ef = 1'b0;
        forever begin
            @(posedge clk);
            if (rst_i) begin
                have = 1'b1; p = 0; sd = '0; sdp = '0; sb = 1'b0; e = '0; ef = 1'b0;
            end else if (have) begin
                e = model_out(p, sd, sdp, sb);
                if (p % FRAME == 0) begin
                    sd = digits_i; sdp = dp_i; sb = blank_lz_i;
                end
                p++;
                ef = (p % FRAME == 0);
            end
            #2;
            if (have) begin
                n_tests++;
                if (o0 !== {ef, e}) begin
                    n_fail++;
                    $display("FAIL model_hi pos=%0d got=%h exp=%h", p, o0, {ef, e});
                end
                n_tests++;
                if (o1 !== {ef, ~e}) begin
                    n_fail++;
                    $display("FAIL model_lo pos=%0d got=%h exp=%h", p, o1, {ef, ~e});
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic rand_inputs();
        int nz;
        logic [15:0] d;
        nz = $urandom_range(0, 4);
        for (int k = 0; k < 4; k++) begin
            d[4*k +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
            if (k >= 4 - nz) d[4*k +: 4] = 4'h0;
        end
        digits_i   = d;
        dp_i       = 4'($urandom_range(0, 15));
        blank_lz_i = 1'($urandom_range(0, 1));
    endtask

    initial begin : stimulus
        rst_i = 1'b1; digits_i = 16'h1234; dp_i = 4'b0100; blank_lz_i = 1'b0;
        repeat (3) @(negedge clk);
        lit("reset_hi", o0, 13'h0000);
        lit("reset_lo", o1, {1'b0, 1'b1, 4'b1111, 7'h7F});
        rst_i = 1'b0;
        cyc = 0;
        lit("cyc0_idle", o0, 13'h0000);
        go_to(2);  lit("blank_cyc2", o0, 13'h0000);
        go_to(3);  lit("d0_1234", o0, {1'b0, 1'b0, 4'b0001, 7'h66});
        go_to(11); lit("d1_1234", o0, {1'b0, 1'b0, 4'b0010, 7'h4F});
        go_to(19); lit("d2_1234_dp", o0, {1'b0, 1'b1, 4'b0100, 7'h5B});
        go_to(27); lit("d3_1234", o0, {1'b0, 1'b0, 4'b1000, 7'h06});
        go_to(31); lit("pre_frame", o0, {1'b0, 1'b0, 4'b1000, 7'h06});
        go_to(32); lit("frame_pulse", o0, {1'b1, 1'b0, 4'b1000, 7'h06});
        go_to(33); lit("post_frame", o0, 13'h0000);
        go_to(34); digits_i = 16'h0070; blank_lz_i = 1'b1;
        go_to(43); lit("snapshot_hold", o0, {1'b0, 1'b0, 4'b0010, 7'h4F});
        go_to(67); lit("lz_d0", o0, {1'b0, 1'b0, 4'b0001, 7'h3F});
        go_to(75); lit("lz_d1", o0, {1'b0, 1'b0, 4'b0010, 7'h07});
        go_to(83); lit("lz_d2_dark", o0, 13'h0000);
        go_to(91); lit("lz_d3_dark", o0, 13'h0000);
        go_to(92); digits_i = 16'h0000;
        go_to(99);  lit("zero_d0", o0, {1'b0, 1'b0, 4'b0001, 7'h3F});
        go_to(100); digits_i = 16'h00A9; blank_lz_i = 1'b0;
        go_to(107); lit("zero_d1_dark", o0, 13'h0000);
        go_to(131); lit("a9_d0", o0, {1'b0, 1'b0, 4'b0001, 7'h6F});
        go_to(139); lit("a9_dash", o0, {1'b0, 1'b0, 4'b0010, 7'h40});
        go_to(147); lit("a9_d2_dp", o0, {1'b0, 1'b1, 4'b0100, 7'h3F});
        go_to(148); rst_i = 1'b1; digits_i = 16'h0008;
        step();
        lit("midslot_rst_hi", o0, 13'h0000);
        lit("midslot_rst_lo", o1, {1'b0, 1'b1, 4'b1111, 7'h7F});
        step();
        rst_i = 1'b0;
        cyc = 0;
        go_to(2); lit("restart_blank", o0, 13'h0000);
        go_to(3);
        lit("restart_d0_hi", o0, {1'b0, 1'b0, 4'b0001, 7'h7F});
        lit("restart_d0_lo", o1, {1'b0, 1'b1, 4'b1110, 7'h00});

        for (int it = 0; it < 60; it++) begin
            rand_inputs();
            repeat ($urandom_range(1, 40)) step();
            if ($urandom_range(0, 19) == 0) begin
                rst_i = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                rst_i = 1'b0;
            end
        end
        repeat (FRAME + 4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
